// File: rtl/mux_rr_param.sv
// ---------------------------------------------------------------------------
// mux_rr_param
// Arbitrated N:1 channel multiplexer with a one-word registered output stage.
// Each cycle one valid input channel is granted (round-robin or fixed lowest-
// index priority) and its word is loaded into the output register whenever
// that register is empty or being drained. Full throughput: a downstream
// accept and a new load complete on the same edge.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   valid_in    in   [NUM_CH]             per-channel word valid
//   data_in     in   [NUM_CH*DATA_WIDTH]  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ready_in    out  [NUM_CH]             one-hot (or zero) accept to the granted channel
//   valid_out   out                       output word valid
//   data_out    out  [DATA_WIDTH]         output word
//   ch_out      out  [CH_BITS]            source channel of data_out
//   ready_out   in                        downstream accept
//   xfer_count  out  [16]                 completed output transfers, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
module mux_rr_param #(
   parameter  int DATA_WIDTH = 8,
   parameter  int NUM_CH     = 4,
   parameter  int ARB_MODE   = 0,   // 0 = round-robin, 1 = fixed priority (lowest index)
   localparam int CH_BITS    = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            valid_in,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   output logic [NUM_CH-1:0]            ready_in,
   output logic                         valid_out,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic [CH_BITS-1:0]           ch_out,
   input  logic                         ready_out,
   output logic [15:0]                  xfer_count
);

   // Registered state
   logic                  valid_q,      valid_d;
   logic [DATA_WIDTH-1:0] data_q,       data_d;
   logic [CH_BITS-1:0]    ch_q,         ch_d;
   logic [CH_BITS-1:0]    last_grant_q, last_grant_d;
   logic [15:0]           xfer_count_q, xfer_count_d;

   // Arbitration and handshake terms
   logic                  load_en;
   logic                  grant_vld;
   logic [CH_BITS-1:0]    grant_idx;
   logic [NUM_CH-1:0]     upper_mask;
   logic [NUM_CH-1:0]     masked_valid;
   logic                  out_xfer;
   logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

   // Index of the lowest set bit; zero when the vector is empty.
   function automatic logic [CH_BITS-1:0] lowest_set(input logic [NUM_CH-1:0] vec);
      lowest_set = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (vec[i]) lowest_set = CH_BITS'(i);
      end
   endfunction

   // Unflatten the channel bus so the granted word is a plain array lookup.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Round-robin as a two-pass priority search: first look only at channels
   // above last_grant, and if none of those are valid fall back to the lowest
   // valid channel overall (the wrap through NUM_CH-1 to 0).
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // so no path through the block leaves a value unassigned (no latch).
      upper_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         upper_mask[i] = (i > int'(last_grant_q));
      end
      masked_valid = valid_in & upper_mask;
      grant_vld    = |valid_in;
      if (ARB_MODE == 1 || masked_valid == '0) begin
         grant_idx = lowest_set(valid_in);
      end else begin
         grant_idx = lowest_set(masked_valid);
      end
   end

   // The output register accepts a new word when empty or draining this cycle.
   assign load_en  = !valid_q || ready_out;
   assign out_xfer = valid_q && ready_out;
   // ready_in already implies valid_in for the granted bit, so any set bit
   // is an input transfer; reset forces it to zero.
   assign ready_in = (grant_vld && load_en && !reset) ? (NUM_CH'(1) << grant_idx) : '0;

   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      ch_d         = ch_q;
      last_grant_d = last_grant_q;
      xfer_count_d = out_xfer ? xfer_count_q + 16'd1 : xfer_count_q;
      if (load_en) begin
         // With nothing valid the register empties but keeps its last word.
         valid_d = grant_vld;
         if (grant_vld) begin
            data_d       = ch_data[grant_idx];
            ch_d         = grant_idx;
            last_grant_d = grant_idx;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its *_d input, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= 1'b0;
         data_q       <= '0;
         ch_q         <= '0;
         xfer_count_q <= '0;
         // Pointing at the top channel makes channel 0 first after reset.
         last_grant_q <= CH_BITS'(NUM_CH - 1);
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         ch_q         <= ch_d;
         xfer_count_q <= xfer_count_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign valid_out  = valid_q;
   assign data_out   = data_q;
   assign ch_out     = ch_q;
   assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_mux_rr_param.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_param
// Bench for mux_rr_param (DATA_WIDTH=8, NUM_CH=4). Two instances share the
// stimulus: one round-robin, one fixed-priority; sel picks which is checked.
// A table of hand-derived vectors is applied first, followed by hand-written
// multi-cycle sequences, a random run in both modes and the counter wrap.
// A behavioural model plus an output scoreboard queue supplies expectations.
// ---------------------------------------------------------------------------
module tb_mux_rr_param;

   logic        clk;
   logic        reset;
   logic [3:0]  valid_in;
   logic [31:0] data_in;
   logic        ready_out;

   logic [3:0]  rdy_rr, rdy_fp;
   logic        vo_rr,  vo_fp;
   logic [7:0]  do_rr,  do_fp;
   logic [1:0]  ch_rr,  ch_fp;
   logic [15:0] cnt_rr, cnt_fp;

   logic        sel;   // 0 = check round-robin instance, 1 = fixed-priority
   logic [3:0]  act_ready;
   logic        act_valid;
   logic [7:0]  act_data;
   logic [1:0]  act_ch;
   logic [15:0] act_count;

   mux_rr_param #(.DATA_WIDTH(8), .NUM_CH(4), .ARB_MODE(0)) dut_rr (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .ready_in   (rdy_rr),
      .valid_out  (vo_rr),
      .data_out   (do_rr),
      .ch_out     (ch_rr),
      .ready_out  (ready_out),
      .xfer_count (cnt_rr)
   );

   mux_rr_param #(.DATA_WIDTH(8), .NUM_CH(4), .ARB_MODE(1)) dut_fp (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .ready_in   (rdy_fp),
      .valid_out  (vo_fp),
      .data_out   (do_fp),
      .ch_out     (ch_fp),
      .ready_out  (ready_out),
      .xfer_count (cnt_fp)
   );

   always_comb begin
      act_ready = sel ? rdy_fp : rdy_rr;
      act_valid = sel ? vo_fp  : vo_rr;
      act_data  = sel ? do_fp  : do_rr;
      act_ch    = sel ? ch_fp  : ch_rr;
      act_count = sel ? cnt_fp : cnt_rr;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters, model, scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;

   logic        m_valid = 1'b0;
   logic [7:0]  m_data  = 8'h00;
   logic [1:0]  m_ch    = 2'd0;
   int          m_last  = 3;
   logic [15:0] m_count = 16'd0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] ch;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic [31:0] d;
      logic        r;
      logic [3:0]  e_ready;
      logic        e_valid;
      logic [1:0]  e_ch;
      logic [7:0]  e_data;
      logic [15:0] e_count;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Grant the model expects for valid vector v; -1 when nothing is valid.
   function automatic int model_grant(input logic [3:0] v);
      if (sel) begin
         for (int i = 0; i < 4; i++) if (v[i]) return i;
      end else begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (v[c]) return c;
         end
      end
      return -1;
   endfunction

   // Drive one cycle, check ready_in before the edge and registered outputs
   // one time unit after it. use_tab adds the hand-derived table expectations.
   task automatic run_vec(input vec_t t, input bit use_tab);
      int         g;
      logic       load;
      logic [3:0] exp_rdy;
      reset     = t.rst;
      valid_in  = t.v;
      data_in   = t.d;
      ready_out = t.r;
      #1;
      load    = !m_valid || t.r;
      g       = model_grant(t.v);
      exp_rdy = (t.rst || !load || g < 0) ? 4'b0000 : 4'(1 << g);
      check("ready_in", 32'(act_ready), 32'(exp_rdy));
      if (use_tab) check("tab_ready_in", 32'(act_ready), 32'(t.e_ready));
      @(posedge clk);
      if (t.rst) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_ch    = 2'd0;
         m_last  = 3;
         m_count = 16'd0;
         sb_q.delete();
      end else begin
         if (m_valid && t.r) begin
            m_count++;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
         end
         if (load) begin
            if (g >= 0) begin
               exp_t e;
               m_valid = 1'b1;
               m_data  = t.d[g*8 +: 8];
               m_ch    = 2'(g);
               m_last  = g;
               e.data  = m_data;
               e.ch    = m_ch;
               sb_q.push_back(e);
            end else begin
               m_valid = 1'b0;
            end
         end
      end
      #1;
      check("valid_out", 32'(act_valid), 32'(m_valid));
      check("xfer_count", 32'(act_count), 32'(m_count));
      if (m_valid && sb_q.size() > 0) begin
         check("sb_data_out", 32'(act_data), 32'(sb_q[0].data));
         check("sb_ch_out", 32'(act_ch), 32'(sb_q[0].ch));
      end else begin
         check("held_data_out", 32'(act_data), 32'(m_data));
         check("held_ch_out", 32'(act_ch), 32'(m_ch));
      end
      if (use_tab) begin
         check("tab_valid_out", 32'(act_valid), 32'(t.e_valid));
         check("tab_ch_out", 32'(act_ch), 32'(t.e_ch));
         check("tab_data_out", 32'(act_data), 32'(t.e_data));
         check("tab_xfer_count", 32'(act_count), 32'(t.e_count));
      end
   endtask

   task automatic step(input logic rst, input logic [3:0] v, input logic [31:0] d, input logic r);
      vec_t t;
      t = '{rst, v, d, r, 4'h0, 1'b0, 2'd0, 8'h00, 16'd0};
      run_vec(t, 1'b0);
   endtask

   // ---------------- test ----------------
   vec_t tab [19];

   initial begin
      logic [3:0] seen;
      int         guard;

      // rst, valid, data, ready_out | ready_in, valid_out, ch_out, data_out, xfer_count
      tab[0]  = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd0};
      tab[1]  = '{1'b0, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5, 16'd0};
      tab[2]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA5, 16'd1};
      tab[3]  = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd0};
      tab[4]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd0};
      tab[5]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 16'd1};
      tab[6]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 16'd2};
      tab[7]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 16'd3};
      tab[8]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 16'd4};
      tab[9]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 16'd5};
      tab[10] = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 16'd6};
      tab[11] = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 16'd7};
      tab[12] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h13, 16'd8};
      tab[13] = '{1'b0, 4'b0001, 32'hFFFFFF42, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h42, 16'd8};
      tab[14] = '{1'b0, 4'b1000, 32'h77665544, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h42, 16'd8};
      tab[15] = '{1'b0, 4'b1000, 32'h77665544, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h77, 16'd9};
      tab[16] = '{1'b0, 4'b0101, 32'h77665544, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h44, 16'd10};
      tab[17] = '{1'b0, 4'b0101, 32'h77665544, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h66, 16'd11};
      tab[18] = '{1'b0, 4'b0101, 32'h77665544, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h44, 16'd12};

      sel = 1'b0;
      for (int i = 0; i < 19; i++) run_vec(tab[i], 1'b1);

      // Held word with downstream stalled, then release loads the next grant.
      step(1'b1, 4'b0000, 32'h0, 1'b1);
      step(1'b0, 4'b0001, 32'h0000003C, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'b0011, 32'h00005A3C, 1'b0);
         check("stall_data_hold", 32'(act_data), 32'h3C);
         check("stall_valid_hold", 32'(act_valid), 32'h1);
      end
      step(1'b0, 4'b0011, 32'h00005A3C, 1'b1);
      check("release_ch", 32'(act_ch), 32'd1);
      check("release_data", 32'(act_data), 32'h5A);

      // Reset while a word is held discards it; channel 0 wins afterwards.
      step(1'b1, 4'b0000, 32'h0, 1'b1);
      step(1'b0, 4'b0100, 32'h00A50000, 1'b0);
      step(1'b0, 4'b0100, 32'h00A50000, 1'b0);
      step(1'b1, 4'b1111, 32'h13121110, 1'b1);
      check("rst_valid_out", 32'(act_valid), 32'h0);
      check("rst_xfer_count", 32'(act_count), 32'h0);
      check("rst_ch_out", 32'(act_ch), 32'h0);
      step(1'b0, 4'b1111, 32'h13121110, 1'b1);
      check("post_rst_ch", 32'(act_ch), 32'd0);
      check("post_rst_count", 32'(act_count), 32'd0);

      // Fixed priority: channel 1 always wins over 2 and 3.
      sel = 1'b1;
      step(1'b1, 4'b0000, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 4'b1110, 32'h13121110, 1'b1);
         check("fp_ch_out", 32'(act_ch), 32'd1);
         check("fp_valid_out", 32'(act_valid), 32'd1);
      end

      // Round-robin fairness: every window of 4 grants covers all channels.
      sel = 1'b0;
      step(1'b1, 4'b0000, 32'h0, 1'b1);
      for (int w = 0; w < 3; w++) begin
         seen = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b1111, 32'h13121110, 1'b1);
            if (act_valid) seen[act_ch] = 1'b1;
         end
         check("rr_fair_window", 32'(seen), 32'hF);
      end

      // Random traffic in both modes against the model and scoreboard.
      for (int m = 0; m < 2; m++) begin
         sel = m[0];
         step(1'b1, 4'b0000, 32'h0, 1'b1);
         for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom), $urandom,
                 ($urandom_range(0, 3) != 0));
         end
      end

      // Counter wrap: stream until the count reaches 16'hFFFE.
      sel = 1'b0;
      step(1'b1, 4'b0000, 32'h0, 1'b1);
      guard = 0;
      while (m_count != 16'hFFFE && guard < 70000) begin
         step(1'b0, 4'b0001, 32'h0000005A, 1'b1);
         guard++;
      end
      check("wrap_pre", 32'(act_count), 32'hFFFE);
      step(1'b0, 4'b0001, 32'h0000005A, 1'b1);
      check("wrap_ffff", 32'(act_count), 32'hFFFF);
      step(1'b0, 4'b0001, 32'h0000005A, 1'b1);
      check("wrap_zero", 32'(act_count), 32'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
